pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches with one configurable block. It carries a packed control word, a valid bit and N data channels, and supports the hazard unit directly through hold (stall) and bubble insertion (flush). Saturating event counters for stalls, flushes and bubbles feed the performance-debug path. One instance sits between each pair of pipeline stages in the datapath.

## Interface
Parameters:
- CTRL_W, 11: width of the packed control word (RegWrite, MemWrite, MemToReg, ...).
- DATA_W, 32: width of each data channel.
- NUM_DATA, 6: number of data channels, at least 1.
- CNT_W, 16: width of each event counter.

Ports:
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- inValid  input  1  the upstream stage holds a real instruction.
- inCtrl  input  CTRL_W  upstream control word.
- inData  input  NUM_DATA*DATA_W  upstream data channels; channel k is bits [k*DATA_W +: DATA_W].
- Stall  input  1  hold the current contents (load-use hazard).
- Flush  input  1  insert a bubble (branch/jump taken).
- CntClear  input  1  synchronous clear of all counters.
- outValid  output  1  the registered stage holds a real instruction.
- outCtrl  output  CTRL_W  registered control word; forced to zero while outValid=0.
- outData  output  NUM_DATA*DATA_W  registered data channels.
- stallCount  output  CNT_W  number of cycles held by Stall.
- flushCount  output  CNT_W  number of valid instructions killed by Flush.
- bubbleCount  output  CNT_W  number of cycles outValid was 0 after an edge.

## Operation
- Reset (asynchronous) sets the following outputs, all at once: outValid=0, outCtrl=0, outData=0, and all three counters = 0.
- Priority per rising edge: Flush, then Stall, then normal load.
- Flush=1 behaviour:
  - outValid<=0 and outCtrl<=0.
  - outData holds its previous value.
  - Any concurrent Stall is ignored.
- Stall=1 with Flush=0: outValid, outCtrl and outData all hold.
- Normal load:
  - outValid<=inValid.
  - outCtrl<=inCtrl if inValid=1, else 0.
  - outData<=inData unconditionally.
- Invariant: outValid=0 implies outCtrl=0. A bubble must never write registers or memory.

Counters:
- All counters saturate at 2^CNT_W-1 and do not wrap.
- stallCount increments on each edge where Stall=1 and Flush=0.
- flushCount increments on each edge where Flush=1 and the pre-edge outValid=1.
- bubbleCount increments on each edge after which outValid=0. This covers flush, invalid load, and a stall of an already-empty stage.
- CntClear=1 on an edge zeroes all counters. Clear wins over an increment on the same edge.
- CntClear has no effect on the pipeline contents.

## Timing
- Latency: 1 cycle from in* to out* on a normal load.
- Stall and Flush are sampled on the same edge as the data. A Flush asserted in cycle t produces outValid=0 in cycle t+1.
- Stall held for k cycles leaves the outputs constant for k cycles. The load resumes on the first edge with Stall=0.
- Reset asserted mid-operation takes effect immediately, with no clock needed. After Reset deasserts, the first edge performs a normal load.
- All outputs come directly from flops; there is no combinational input-to-output path.
- Counter values update on the same edge as the event that increments them.

## Structure
- Shared package pipe_pkg holds:
  - control-bit index constants (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_MEMREAD, CTRL_MEMTOREG_LO/HI, ...);
  - default CTRL_W and DATA_W values;
  - per-stage NUM_DATA constants (IFID_NUM_DATA=2, IDEX_NUM_DATA=5, EXMEM_NUM_DATA=6, MEMWB_NUM_DATA=4).
- Sub-module sat_counter:
  - parameter W;
  - ports Clk, Reset, clr, inc, count;
  - behaviour: saturating, clear-over-increment.
  - It is instantiated three times.
- The data channels use one generate loop over NUM_DATA.

## Test plan
- Reset with inValid=1, inCtrl=11'h7FF, inData all 32'hDEADBEEF, Reset held high across an edge -> all outputs stay 0; on the first edge after release outValid=1, outCtrl=11'h7FF, every channel reads 32'hDEADBEEF.
- Load 0x11 with Stall=1 for 3 cycles, presenting new inData 0x22 during the stall -> outputs remain 0x11 for 3 cycles; stallCount=3; 0x22 appears on the edge after Stall drops.
- Valid instruction in the stage, then Flush=1 and Stall=1 together -> outValid=0, outCtrl=0, outData unchanged; flushCount=1, bubbleCount=1, stallCount unchanged.
- inValid=0 with inCtrl=11'h155 -> outCtrl=0, outValid=0, outData=inData, bubbleCount increments.
- CNT_W=4, Stall held for 20 cycles -> stallCount stops at 15. Then CntClear and Stall together on one edge -> stallCount=0.
- Reset pulsed between edges while outValid=1 -> outputs and counters go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit layout, default widths, per-stage
// channel counts and the per-edge stage operation decode.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 11;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 16;

  // Control-word bit positions shared by all stage instances.
  localparam int CTRL_REGWRITE    = 0;
  localparam int CTRL_MEMWRITE    = 1;
  localparam int CTRL_MEMREAD     = 2;
  localparam int CTRL_MEMTOREG_LO = 3;
  localparam int CTRL_MEMTOREG_HI = 4;
  localparam int CTRL_ALUSRC      = 5;
  localparam int CTRL_ALUOP_LO    = 6;
  localparam int CTRL_ALUOP_HI    = 8;
  localparam int CTRL_BRANCH      = 9;
  localparam int CTRL_JUMP        = 10;

  localparam int IFID_NUM_DATA  = 2;
  localparam int IDEX_NUM_DATA  = 5;
  localparam int EXMEM_NUM_DATA = 6;
  localparam int MEMWB_NUM_DATA = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_HOLD  = 2'd1,
    OP_FLUSH = 2'd2
  } stage_op_e;

  // Flush outranks Stall, which outranks a normal load.
  function automatic stage_op_e decode_op(input logic flush, input logic stall);
    if (flush)      return OP_FLUSH;
    else if (stall) return OP_HOLD;
    else            return OP_LOAD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable pipeline stage register with stall/flush support and
// saturating stall, flush and bubble event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int NUM_DATA = 6,
  parameter int CNT_W    = PIPE_CNT_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       inValid,
  input  logic [CTRL_W-1:0]          inCtrl,
  input  logic [NUM_DATA*DATA_W-1:0] inData,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic                       CntClear,
  output logic                       outValid,
  output logic [CTRL_W-1:0]          outCtrl,
  output logic [NUM_DATA*DATA_W-1:0] outData,
  output logic [CNT_W-1:0]           stallCount,
  output logic [CNT_W-1:0]           flushCount,
  output logic [CNT_W-1:0]           bubbleCount
);

  stage_op_e         op;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    op      = decode_op(Flush, Stall);
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    unique case (op)
      OP_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      OP_LOAD: begin
        valid_d = inValid;
        // A bubble carries an all-zero control word so it never writes state.
        ctrl_d  = inValid ? inCtrl : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  for (genvar k = 0; k < NUM_DATA; k++) begin : g_chan
    logic [DATA_W-1:0] data_q;

    // NOTE: data registers are reset too, so a fresh stage reads as all zero.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)              data_q <= '0;
      else if (op == OP_LOAD) data_q <= inData[k*DATA_W +: DATA_W];
    end

    assign outData[k*DATA_W +: DATA_W] = data_q;
  end

  logic inc_stall, inc_flush, inc_bubble;

  assign inc_stall  = (op == OP_HOLD);
  assign inc_flush  = Flush & valid_q;
  assign inc_bubble = ~valid_d;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (CntClear),
    .inc   (inc_stall),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (CntClear),
    .inc   (inc_flush),
    .count (flushCount)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (CntClear),
    .inc   (inc_bubble),
    .count (bubbleCount)
  );

  assign outValid = valid_q;
  assign outCtrl  = ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: a wide-counter and a
// 4-bit-counter instance share stimulus and are checked against one model.
module tb_pipe_stage_reg;

  localparam int CTRL_W   = 11;
  localparam int DATA_W   = 32;
  localparam int NUM_DATA = 6;
  localparam int DW       = NUM_DATA * DATA_W;
  localparam int BIG_MAX  = 65535;
  localparam int SML_MAX  = 15;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              inValid;
  logic [CTRL_W-1:0] inCtrl;
  logic [DW-1:0]     inData;
  logic              Stall, Flush, CntClear;

  logic              b_valid, s_valid;
  logic [CTRL_W-1:0] b_ctrl, s_ctrl;
  logic [DW-1:0]     b_data, s_data;
  logic [15:0]       b_stc, b_flc, b_bbc;
  logic [3:0]        s_stc, s_flc, s_bbc;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CNT_W(16)) u_big (
    .Clk(Clk), .Reset(Reset), .inValid(inValid), .inCtrl(inCtrl), .inData(inData),
    .Stall(Stall), .Flush(Flush), .CntClear(CntClear),
    .outValid(b_valid), .outCtrl(b_ctrl), .outData(b_data),
    .stallCount(b_stc), .flushCount(b_flc), .bubbleCount(b_bbc)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CNT_W(4)) u_small (
    .Clk(Clk), .Reset(Reset), .inValid(inValid), .inCtrl(inCtrl), .inData(inData),
    .Stall(Stall), .Flush(Flush), .CntClear(CntClear),
    .outValid(s_valid), .outCtrl(s_ctrl), .outData(s_data),
    .stallCount(s_stc), .flushCount(s_flc), .bubbleCount(s_bbc)
  );

  always #5 Clk = ~Clk;

  // Reference model: plain state plus unbounded event counts; saturation is
  // applied only when comparing against each instance's counter width.
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DW-1:0]     m_data;
  int                m_stall, m_flush, m_bubble;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_data = '0;
    m_stall = 0; m_flush = 0; m_bubble = 0;
  endtask

  // Counts are tracked exactly; since every counter only grows by one per
  // edge, min(count, limit) equals the saturating hardware value.
  task automatic model_edge();
    logic was_valid;
    if (Reset) begin
      model_reset();
      return;
    end
    was_valid = m_valid;
    if (Flush) begin
      m_valid = 1'b0; m_ctrl = '0;
    end else if (!Stall) begin
      m_valid = inValid;
      m_ctrl  = inValid ? inCtrl : '0;
      m_data  = inData;
    end
    if (CntClear) begin
      m_stall = 0; m_flush = 0; m_bubble = 0;
    end else begin
      if (Stall && !Flush) m_stall++;
      if (Flush && was_valid) m_flush++;
      if (!m_valid) m_bubble++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  b_valid, m_valid);
    check({tag, ".ctrl"},   b_ctrl,  m_ctrl);
    check({tag, ".data"},   b_data,  m_data);
    check({tag, ".stc"},    b_stc,   sat(m_stall,  BIG_MAX));
    check({tag, ".flc"},    b_flc,   sat(m_flush,  BIG_MAX));
    check({tag, ".bbc"},    b_bbc,   sat(m_bubble, BIG_MAX));
    check({tag, ".s_valid"}, s_valid, m_valid);
    check({tag, ".s_ctrl"},  s_ctrl,  m_ctrl);
    check({tag, ".s_data"},  s_data,  m_data);
    check({tag, ".s_stc"},   s_stc,   sat(m_stall,  SML_MAX));
    check({tag, ".s_flc"},   s_flc,   sat(m_flush,  SML_MAX));
    check({tag, ".s_bbc"},   s_bbc,   sat(m_bubble, SML_MAX));
  endtask

  // Inputs change at the falling edge; outputs are compared there too.
  task automatic step(input string tag);
    model_edge();
    @(posedge Clk);
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic st, input logic fl, input logic clr);
    inValid = v; inCtrl = c; inData = {NUM_DATA{d}};
    Stall = st; Flush = fl; CntClear = clr;
  endtask

  task automatic reset_pulse(input string tag);
    Reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [DW-1:0] snap;
    Reset = 1'b1;
    model_reset();
    set_in(1'b1, 11'h7FF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    step("rst_hold");
    check("rst_hold.valid0", b_valid, 1'b0);
    check("rst_hold.data0",  b_data,  '0);

    Reset = 1'b0;
    step("rst_release");
    check("rst_release.valid", b_valid, 1'b1);
    check("rst_release.ctrl",  b_ctrl,  11'h7FF);
    check("rst_release.data",  b_data,  {NUM_DATA{32'hDEADBEEF}});

    // Stall holds the stage while new data waits upstream.
    set_in(1'b1, 11'h011, 32'h11, 1'b0, 1'b0, 1'b1);
    step("load11");
    set_in(1'b1, 11'h022, 32'h22, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.data", b_data, {NUM_DATA{32'h11}});
    end
    check("stall.count3", b_stc, 16'd3);
    Stall = 1'b0;
    step("unstall");
    check("unstall.data", b_data, {NUM_DATA{32'h22}});

    // Flush together with Stall: flush wins, data holds.
    snap = b_data;
    set_in(1'b1, 11'h3C3, 32'h33, 1'b1, 1'b1, 1'b1);
    step("preflush_clr");
    set_in(1'b1, 11'h3C3, 32'h44, 1'b0, 1'b0, 1'b0);
    step("reload");
    snap = {NUM_DATA{32'h44}};
    set_in(1'b1, 11'h155, 32'h55, 1'b1, 1'b1, 1'b0);
    step("flush_stall");
    check("flush_stall.valid", b_valid, 1'b0);
    check("flush_stall.ctrl",  b_ctrl,  '0);
    check("flush_stall.data",  b_data,  snap);
    check("flush_stall.flc",   b_flc,   16'd1);
    check("flush_stall.bbc",   b_bbc,   16'd1);
    check("flush_stall.stc",   b_stc,   16'd0);

    // Invalid load: control forced to zero, data still captured.
    set_in(1'b0, 11'h155, 32'h66, 1'b0, 1'b0, 1'b0);
    step("invalid_load");
    check("invalid_load.ctrl", b_ctrl, '0);
    check("invalid_load.data", b_data, {NUM_DATA{32'h66}});
    check("invalid_load.bbc",  b_bbc,  16'd2);

    // Saturation of the 4-bit counters, then clear beats increment.
    set_in(1'b1, 11'h0AA, 32'h77, 1'b0, 1'b0, 1'b1);
    step("sat_clr");
    Stall = 1'b1; CntClear = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_stall");
    check("sat.s_stc15", s_stc, 4'd15);
    check("sat.b_stc20", b_stc, 16'd20);
    CntClear = 1'b1;
    step("sat_clear");
    check("sat_clear.s_stc", s_stc, 4'd0);

    // Asynchronous reset between edges while a valid instruction is held.
    set_in(1'b1, 11'h1FF, 32'h88, 1'b0, 1'b0, 1'b0);
    step("pre_pulse");
    reset_pulse("rst_pulse");
    check("rst_pulse.valid", b_valid, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      inValid  = 1'($urandom_range(0, 3) != 0);
      inCtrl   = CTRL_W'($urandom);
      for (int k = 0; k < NUM_DATA; k++) inData[k*DATA_W +: DATA_W] = $urandom;
      Stall    = 1'($urandom_range(0, 3) == 0);
      Flush    = 1'($urandom_range(0, 5) == 0);
      CntClear = 1'($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 79) == 0) reset_pulse("rnd_rst");
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
